instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 26 ++
 rtl/instr_loader_word_asm.sv | 57 +++++
 rtl/instr_loader.sv | 181 ++++++++++++++++++
 tb/tb_instr_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM states and sticky error codes.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_LEN     = 2'b01,
        ERR_CHK     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_e;

    // True in the states where a frame byte is expected and the idle timer runs.
    function automatic logic is_loading(input state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/instr_loader_word_asm.sv
// Byte-to-word assembler: MSB-first shift register, byte-in-word counter and
// XOR checksum over every data byte. word_done pulses the cycle after the
// 4th byte of a word, while word still holds that complete word.
module loader_word_asm (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done,
    output logic [7:0]  chk
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  chk_q, chk_d;
    logic        done_q, done_d;

    // Shift in accepted bytes, fold them into the checksum, flag word completion.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        chk_d  = chk_q;
        done_d = 1'b0;
        if (clear) begin
            word_d = '0;
            cnt_d  = '0;
            chk_d  = '0;
        end else if (byte_en) begin
            word_d = {word_q[23:0], byte_in};
            cnt_d  = cnt_q + 2'd1;
            chk_d  = chk_q ^ byte_in;
            done_d = (cnt_q == 2'd3);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
            chk_q  <= '0;
            done_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            chk_q  <= chk_d;
            done_q <= done_d;
        end
    end

    assign word      = word_q;
    assign word_done = done_q;
    assign chk       = chk_q;

endmodule

// File: rtl/instr_loader.sv
// Boot-time instruction loader: receives a length-prefixed, checksummed byte
// frame, writes assembled 32-bit words to instruction memory and holds the CPU
// in reset until a session completes cleanly.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int          IMEM_AW = 8,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic [1:0]         err
);

    localparam logic [16:0] CAPACITY = 17'd1 << IMEM_AW;

    state_e             state_q, state_d;
    err_e               err_q, err_d;
    logic [7:0]         len_hi_q, len_hi_d;
    logic [15:0]        len_q, len_d;
    logic [IMEM_AW:0]   wi_q, wi_d;
    logic [15:0]        idle_q, idle_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d;

    logic               asm_clear;
    logic               byte_en;
    logic               xfer;
    logic               last_word;
    logic [15:0]        len_n;
    logic [31:0]        word;
    logic               word_done;
    logic [7:0]         chk;

    loader_word_asm u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .byte_en   (byte_en),
        .byte_in   (rx_data),
        .word      (word),
        .word_done (word_done),
        .chk       (chk)
    );

    // The final word's write cycle: stop accepting so the checksum byte is
    // never mistaken for data; the FSM moves to CHK on this cycle.
    assign last_word = word_done && (16'(wi_q) == len_q - 16'd1);
    assign len_n     = {len_hi_q, rx_data};
    assign xfer      = rx_valid && rx_ready;
    assign byte_en   = xfer && (state_q == ST_DATA);

    // Byte acceptance depends on the state only (plus the last-word stall).
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            ST_LEN_HI, ST_LEN_LO, ST_CHK: rx_ready = 1'b1;
            ST_DATA:                      rx_ready = !last_word;
            default:                      rx_ready = 1'b0;
        endcase
    end

    // Next-state logic: frame parsing, length check, word index and idle timeout.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        wi_d       = wi_q;
        idle_d     = idle_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        asm_clear  = 1'b0;

        if (word_done) wi_d = wi_q + 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LEN_HI;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = ERR_NONE;
                    wi_d       = '0;
                    idle_d     = '0;
                    len_hi_d   = '0;
                    len_d      = '0;
                    asm_clear  = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = rx_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d = len_n;
                    if (len_n == 16'd0) begin
                        state_d = ST_CHK;
                    end else if ({1'b0, len_n} > CAPACITY) begin
                        state_d = ST_ERR;
                        err_d   = ERR_LEN;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (last_word) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (xfer) begin
                    if (rx_data == chk) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_CHK;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A transfer always clears the idle timer, even on the timeout cycle.
        if (is_loading(state_q)) begin
            if (xfer) begin
                idle_d = '0;
            end else if (({1'b0, idle_q} + 17'd1) >= {1'b0, TIMEOUT}) begin
                idle_d  = '0;
                state_d = ST_ERR;
                err_d   = ERR_TIMEOUT;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end
    end

    // State registers; reset abandons any session and re-holds the CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            err_q      <= ERR_NONE;
            len_hi_q   <= '0;
            len_q      <= '0;
            wi_q       <= '0;
            idle_q     <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            wi_q       <= wi_d;
            idle_q     <= idle_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
        end
    end

    assign imem_we    = word_done;
    assign imem_addr  = wi_q[IMEM_AW-1:0];
    assign imem_wdata = word;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a frame-level model predicts the memory
// writes and final status of each session; a per-cycle monitor matches every
// imem_we pulse against the predicted write list.
module tb_instr_loader;

    localparam int AW = 8;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic [1:0]    err;

    instr_loader #(.IMEM_AW(AW), .TIMEOUT(16'd8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        exp_q[$];
    logic       exp_done;
    logic [1:0] exp_err;
    logic       exp_hold;
    logic [7:0] exp_chk;
    int         vec_cnt = 0;
    int         miss_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Frame-level model: given the whole frame and how many bytes were really
    // transferred, predict the writes and the final status.
    task automatic model_frame(input logic [7:0] fr[$], input int sent, input bit aborted);
        int n;
        int need;
        n = (fr.size() >= 2) ? int'({fr[0], fr[1]}) : 0;
        exp_done = 1'b0;
        exp_err  = 2'b00;
        exp_hold = 1'b1;
        exp_chk  = 8'h00;
        if (aborted) begin
            // words complete before the reset still get written
        end
        if (sent >= 2 && n > CAP) begin
            if (!aborted) exp_err = 2'b01;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (2 + 4*i + 3 < sent) begin
                wr_t w;
                w.addr = AW'(i);
                w.data = {fr[2+4*i], fr[3+4*i], fr[4+4*i], fr[5+4*i]};
                exp_q.push_back(w);
            end
        end
        for (int i = 2; i < 2 + 4*n && i < fr.size(); i++) exp_chk ^= fr[i];
        need = 2 + 4*n + 1;
        if (aborted) return;
        if (sent >= need) begin
            if (fr[need-1] == exp_chk) begin
                exp_done = 1'b1;
                exp_hold = 1'b0;
            end else begin
                exp_err = 2'b10;
            end
        end else begin
            exp_err = 2'b11;
        end
    endtask

    // Every write strobe must match the next predicted write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_imem_we", {24'h0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("imem_addr", {24'h0, imem_addr}, {24'h0, w.addr});
                chk("imem_wdata", imem_wdata, w.data);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!rx_ready) begin
            chk("rx_ready_wait", {31'h0, rx_ready}, 32'h1);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            send(fr[i]);
            if (gap > 0 && (i % 37) == 36) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic start_check(input string nm);
        pulse_start();
        chk({nm, "_start_hold"}, {31'h0, cpu_hold}, 32'h1);
        chk({nm, "_start_done"}, {31'h0, done}, 32'h0);
        chk({nm, "_start_err"}, {30'h0, err}, 32'h0);
        chk({nm, "_start_ready"}, {31'h0, rx_ready}, 32'h1);
    endtask

    task automatic end_check(input string nm);
        repeat (3) @(negedge clk);
        chk({nm, "_done"}, {31'h0, done}, {31'h0, exp_done});
        chk({nm, "_err"}, {30'h0, err}, {30'h0, exp_err});
        chk({nm, "_hold"}, {31'h0, cpu_hold}, {31'h0, exp_hold});
        chk({nm, "_ready"}, {31'h0, rx_ready}, 32'h0);
        chk({nm, "_pending_writes"}, exp_q.size(), 32'h0);
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] x;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, rx_ready}, 32'h0);
        chk("rst_we", {31'h0, imem_we}, 32'h0);
        chk("rst_addr", {24'h0, imem_addr}, 32'h0);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_hold", {31'h0, cpu_hold}, 32'h1);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {30'h0, err}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // single-word frame
        fr = '{8'h00, 8'h01, 8'h3C, 8'h08, 8'h00, 8'h01, 8'h35};
        model_frame(fr, fr.size(), 1'b0);
        chk("pin_f1_nwr", exp_q.size(), 32'd1);
        chk("pin_f1_word", exp_q[0].data, 32'h3C08_0001);
        chk("pin_f1_chk", {24'h0, exp_chk}, 32'h35);
        start_check("f1");
        send_frame(fr, fr.size(), 0);
        end_check("f1");
        chk("f1_done_lit", {31'h0, done}, 32'h1);
        chk("f1_hold_lit", {31'h0, cpu_hold}, 32'h0);

        // empty frame
        fr = '{8'h00, 8'h00, 8'h00};
        model_frame(fr, fr.size(), 1'b0);
        chk("pin_f2_done", {31'h0, exp_done}, 32'h1);
        start_check("f2");
        send_frame(fr, fr.size(), 0);
        end_check("f2");

        // length 257 exceeds 256-word memory
        fr = '{8'h01, 8'h01};
        model_frame(fr, fr.size(), 1'b0);
        chk("pin_f3_err", {30'h0, exp_err}, 32'h1);
        start_check("f3");
        send_frame(fr, fr.size(), 0);
        end_check("f3");

        // two words, corrupted checksum
        fr = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hB1, 8'hC2, 8'hD3};
        x = 8'h00;
        for (int i = 2; i < 10; i++) x ^= fr[i];
        fr.push_back(x ^ 8'hFF);
        model_frame(fr, fr.size(), 1'b0);
        chk("pin_f4_nwr", exp_q.size(), 32'd2);
        chk("pin_f4_addr1", {24'h0, exp_q[1].addr}, 32'h1);
        chk("pin_f4_err", {30'h0, exp_err}, 32'h2);
        start_check("f4");
        send_frame(fr, fr.size(), 0);
        end_check("f4");

        // timeout after length bytes: 7 idle cycles are fine, the 8th trips
        fr = '{8'h00, 8'h02};
        model_frame(fr, fr.size(), 1'b0);
        start_check("f5");
        send_frame(fr, fr.size(), 0);
        repeat (7) @(negedge clk);
        chk("f5_err_at7", {30'h0, err}, 32'h0);
        @(negedge clk);
        chk("f5_err_at8", {30'h0, err}, 32'h3);
        end_check("f5");

        // reset on the 2nd byte of word 1 abandons the session
        fr = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
        model_frame(fr, 7, 1'b1);
        chk("pin_f6_nwr", exp_q.size(), 32'd1);
        start_check("f6");
        send_frame(fr, 7, 0);
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = fr[7];
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        end_check("f6");

        // valid single-word frame after the aborted one
        fr = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        fr.push_back(8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D);
        model_frame(fr, fr.size(), 1'b0);
        start_check("f7");
        send_frame(fr, fr.size(), 0);
        end_check("f7");

        // full-capacity frame with idle gaps and an ignored mid-session start
        fr = '{8'h01, 8'h00};
        x = 8'h00;
        for (int i = 0; i < 4*CAP; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            fr.push_back(b);
            x ^= b;
        end
        fr.push_back(x);
        model_frame(fr, fr.size(), 1'b0);
        chk("pin_f8_nwr", exp_q.size(), CAP);
        chk("pin_f8_lastaddr", {24'h0, exp_q[CAP-1].addr}, 32'hFF);
        start_check("f8");
        send_frame(fr, 400, 5);
        pulse_start();
        chk("f8_midstart_hold", {31'h0, cpu_hold}, 32'h1);
        for (int i = 400; i < fr.size(); i++) send(fr[i]);
        end_check("f8");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
